div_share_scheduler: RTL and testbench
======================================

Name: div_share_scheduler

Overview:
- Round-robin scheduler that shares one pipelined signed divider (the avg_div instance) between N_REQ requesters, e.g. several moving-average channels in the recon datapath.
- Accepts one numerator/denominator pair per enabled cycle and drives the divider operands.
- Tracks each in-flight operation with a tag pipeline and returns each quotient with the requester id and a divide-by-zero flag.

Parameters:
- N_REQ, 4, number of requesters (2..8)
- NUMER_WIDTH, 48, signed numerator width
- DENOM_WIDTH, 32, signed denominator width
- RES_WIDTH, 32, signed quotient and remainder width returned to requesters
- DIV_LATENCY, 24, divider pipeline depth in enabled clocks (operand registered to quotient valid)

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous active-high reset
- clk_en  in  1  clock enable; all state advances only when high; the divider clken is tied to the same signal
- chan_enable  in  N_REQ  per-requester enable mask; a masked requester is never granted
- req_valid  in  N_REQ  request pending, one bit per requester
- req_ready  out  N_REQ  one-hot grant; handshake = req_valid[i] & req_ready[i] at an enabled edge
- req_numer  in  N_REQ*NUMER_WIDTH  flattened numerators; requester i occupies slice i
- req_denom  in  N_REQ*DENOM_WIDTH  flattened denominators
- div_numer  out  NUMER_WIDTH  registered operand to the divider
- div_denom  out  DENOM_WIDTH  registered operand to the divider
- div_quotient  in  RES_WIDTH  divider quotient
- div_remain  in  RES_WIDTH  divider remainder
- res_valid  out  1  result strobe, high for one enabled cycle
- res_id  out  $clog2(N_REQ)  requester that owns the result
- res_quotient  out  RES_WIDTH  result quotient
- res_remain  out  RES_WIDTH  result remainder
- res_div_zero  out  1  result came from a zero denominator
- in_flight  out  $clog2(DIV_LATENCY+2)  number of accepted, not yet returned operations

Behaviour:
- Reset: synchronous, active-high, takes effect regardless of clk_en. After reset:
  - all outputs are 0: req_ready, div_numer, div_denom, res_*, in_flight
  - tag pipeline is cleared
  - round-robin pointer is set so requester 0 has highest priority
  - the divider aclr is driven from reset.
- Arbitration (combinational):
  - eligible = req_valid & chan_enable; req_ready = 0 whenever clk_en=0 or reset=1.
  - Otherwise grant the first eligible requester searching upward from (last_grant+1) mod N_REQ; at most one bit is set.
  - last_grant updates only on a handshake.
- Issue: on a handshake at an enabled edge E0, the granted slices are registered into div_numer/div_denom.
- Tag pipeline: a DIV_LATENCY+1 deep shift register of {valid, id, zero}, advanced only when clk_en=1. Cycles without a handshake insert valid=0.
- Divide by zero: if the granted denominator is 0:
  - div_denom is driven to 1 and zero=1 in the tag.
  - At output, res_quotient is RES_WIDTH max positive (0x7FFFFFFF) if numerator >= 0, otherwise min negative (0x80000000).
  - res_remain = 0 and res_div_zero = 1.
- Output:
  - At enabled edge E0+DIV_LATENCY+1, res_* register {tag, div_quotient, div_remain} and res_valid equals the tag valid bit.
  - Latency is DIV_LATENCY+1 enabled edges after the handshake edge.
  - res_valid, res_id and the result data hold their values while clk_en=0.
- Ordering and backpressure:
  - Results return strictly in issue order.
  - There is no result backpressure; consumers must accept every res_valid.
  - Peak throughput is one operation per enabled cycle.
- Divider arithmetic is signed: quotient truncates toward zero and the remainder takes the numerator's sign. The bench model must match this.
- in_flight:
  - increments on a handshake and decrements on res_valid at the same enabled edge; unchanged if both occur.
  - never exceeds DIV_LATENCY+1 and never underflows.
- chan_enable changes take effect on the next arbitration; operations already in flight still complete.
- Reset mid-operation: all in-flight results are dropped. No res_valid is produced for them, including the cycle after reset deasserts.
- Everything is single-clock; there are no multicycle paths.

Test Plan:
- Single op: requester 0 sends numer=1000, denom=7 with clk_en tied 1 -> req_ready[0] high that cycle; res_valid exactly 25 clocks later with res_id=0, quotient=142, remain=6, in_flight 1 -> 0.
- Fairness: requesters 0..3 hold valid continuously -> grants 0,1,2,3,0,... with one per cycle; results return in the same id order, back-to-back.
- Signed and zero denominator: numer=-1000, denom=7 -> quotient=-142, remain=-6. numer=-5, denom=0 -> quotient=0x80000000, remain=0, div_zero=1. numer=5, denom=0 -> quotient=0x7FFFFFFF.
- clk_en gating: clk_en alternates 1/0 -> req_ready=0 on disabled cycles; latency measured as 25 enabled edges; res_* hold across disabled cycles.
- Masking: chan_enable=4'b1011 with all requesters valid -> requester 2 is never granted; the others rotate 0,1,3.
- Reset mid-flight: issue 5 ops, assert reset for 1 cycle at op 3 -> no res_valid afterwards, in_flight=0, the next grant goes to requester 0.

Source files
------------

// File: rtl/div_share_scheduler.sv
// Round-robin scheduler sharing one pipelined signed divider between N_REQ requesters.
// A tag pipeline matched to the divider depth routes every quotient back to its owner in issue order.
module div_share_scheduler #(
    parameter int N_REQ       = 4,
    parameter int NUMER_WIDTH = 48,
    parameter int DENOM_WIDTH = 32,
    parameter int RES_WIDTH   = 32,
    parameter int DIV_LATENCY = 24
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               clk_en,
    input  logic [N_REQ-1:0]                   chan_enable,
    input  logic [N_REQ-1:0]                   req_valid,
    output logic [N_REQ-1:0]                   req_ready,
    input  logic [N_REQ*NUMER_WIDTH-1:0]       req_numer,
    input  logic [N_REQ*DENOM_WIDTH-1:0]       req_denom,
    output logic [NUMER_WIDTH-1:0]             div_numer,
    output logic [DENOM_WIDTH-1:0]             div_denom,
    input  logic [RES_WIDTH-1:0]               div_quotient,
    input  logic [RES_WIDTH-1:0]               div_remain,
    output logic                               res_valid,
    output logic [$clog2(N_REQ)-1:0]           res_id,
    output logic [RES_WIDTH-1:0]               res_quotient,
    output logic [RES_WIDTH-1:0]               res_remain,
    output logic                               res_div_zero,
    output logic [$clog2(DIV_LATENCY+2)-1:0]   in_flight
);
    localparam int ID_W  = $clog2(N_REQ);
    localparam int CNT_W = $clog2(DIV_LATENCY + 2);
    localparam logic [RES_WIDTH-1:0] Q_POS_MAX = {1'b0, {(RES_WIDTH-1){1'b1}}};
    localparam logic [RES_WIDTH-1:0] Q_NEG_MIN = {1'b1, {(RES_WIDTH-1){1'b0}}};

    typedef struct packed {
        logic            valid;
        logic [ID_W-1:0] id;
        logic            zero;
        logic            neg;   // numerator sign, selects the saturation direction for a zero denominator
    } tag_t;

    tag_t                   tag_pipe [DIV_LATENCY+1];
    tag_t                   tag_in;
    tag_t                   tag_out;
    logic [ID_W-1:0]        last_grant;
    logic [ID_W-1:0]        grant_idx;
    logic                   grant_hit;
    logic                   handshake;
    logic [N_REQ-1:0]       eligible;
    logic [NUMER_WIDTH-1:0] sel_numer;
    logic [DENOM_WIDTH-1:0] sel_denom;
    logic                   sel_zero;

    // NOTE: every variable gets a default at the top of always_comb so no path can infer a latch.
    always_comb begin
        eligible  = req_valid & chan_enable;
        grant_hit = 1'b0;
        grant_idx = '0;
        req_ready = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (!grant_hit && eligible[(int'(last_grant) + 1 + k) % N_REQ]) begin
                grant_hit = 1'b1;
                grant_idx = ID_W'((int'(last_grant) + 1 + k) % N_REQ);
            end
        end
        if (grant_hit && clk_en && !reset) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    assign handshake = |req_ready;
    assign sel_numer = req_numer[int'(grant_idx)*NUMER_WIDTH +: NUMER_WIDTH];
    assign sel_denom = req_denom[int'(grant_idx)*DENOM_WIDTH +: DENOM_WIDTH];
    assign sel_zero  = (sel_denom == '0);
    assign tag_out   = tag_pipe[DIV_LATENCY];

    always_comb begin
        tag_in       = '0;
        tag_in.valid = handshake;
        tag_in.id    = grant_idx;
        tag_in.zero  = sel_zero;
        tag_in.neg   = sel_numer[NUMER_WIDTH-1];
    end

    // NOTE: the whole tag pipeline is reset, not just its last stage, so no stale valid bit survives reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i <= DIV_LATENCY; i++) begin
                tag_pipe[i] <= '0;
            end
            last_grant   <= ID_W'(N_REQ - 1);
            div_numer    <= '0;
            div_denom    <= '0;
            res_valid    <= 1'b0;
            res_id       <= '0;
            res_quotient <= '0;
            res_remain   <= '0;
            res_div_zero <= 1'b0;
            in_flight    <= '0;
        end else if (clk_en) begin
            // NOTE: non-blocking assignments let every stage sample its neighbour's pre-edge value.
            tag_pipe[0] <= tag_in;
            for (int i = 1; i <= DIV_LATENCY; i++) begin
                tag_pipe[i] <= tag_pipe[i-1];
            end

            if (handshake) begin
                last_grant <= grant_idx;
                div_numer  <= sel_numer;
                div_denom  <= sel_zero ? DENOM_WIDTH'(1) : sel_denom;
            end

            res_valid <= tag_out.valid;
            if (tag_out.valid) begin
                res_id       <= tag_out.id;
                res_div_zero <= tag_out.zero;
                if (tag_out.zero) begin
                    res_quotient <= tag_out.neg ? Q_NEG_MIN : Q_POS_MAX;
                    res_remain   <= '0;
                end else begin
                    res_quotient <= div_quotient;
                    res_remain   <= div_remain;
                end
            end

            if (handshake && !tag_out.valid) begin
                in_flight <= in_flight + CNT_W'(1);
            end else if (!handshake && tag_out.valid) begin
                in_flight <= in_flight - CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_div_share_scheduler.sv
// Randomised and directed bench for div_share_scheduler with a behavioural divider and a queue-based
// reference model of grants, result timing and in-flight count.
module tb_div_share_scheduler;
    localparam int N   = 4;
    localparam int NW  = 48;
    localparam int DW  = 32;
    localparam int RW  = 32;
    localparam int L   = 24;
    localparam int IDW = $clog2(N);
    localparam int CW  = $clog2(L + 2);

    logic              clk = 1'b0;
    logic              reset;
    logic              clk_en;
    logic [N-1:0]      chan_enable;
    logic [N-1:0]      req_valid;
    logic [N-1:0]      req_ready;
    logic [N*NW-1:0]   req_numer;
    logic [N*DW-1:0]   req_denom;
    logic [NW-1:0]     div_numer;
    logic [DW-1:0]     div_denom;
    logic [RW-1:0]     div_quotient;
    logic [RW-1:0]     div_remain;
    logic              res_valid;
    logic [IDW-1:0]    res_id;
    logic [RW-1:0]     res_quotient;
    logic [RW-1:0]     res_remain;
    logic              res_div_zero;
    logic [CW-1:0]     in_flight;

    div_share_scheduler #(
        .N_REQ(N), .NUMER_WIDTH(NW), .DENOM_WIDTH(DW), .RES_WIDTH(RW), .DIV_LATENCY(L)
    ) dut (
        .clk(clk), .reset(reset), .clk_en(clk_en), .chan_enable(chan_enable),
        .req_valid(req_valid), .req_ready(req_ready), .req_numer(req_numer), .req_denom(req_denom),
        .div_numer(div_numer), .div_denom(div_denom), .div_quotient(div_quotient), .div_remain(div_remain),
        .res_valid(res_valid), .res_id(res_id), .res_quotient(res_quotient), .res_remain(res_remain),
        .res_div_zero(res_div_zero), .in_flight(in_flight)
    );

    always #5 clk = ~clk;

    // Behavioural pipelined divider: L enabled clocks from registered operand to quotient.
    logic [RW-1:0] pq [L];
    logic [RW-1:0] pr [L];

    function automatic logic [2*RW-1:0] plant_div(input logic [NW-1:0] num, input logic [DW-1:0] den);
        longint n;
        longint d;
        n = longint'($signed(num));
        d = longint'($signed(den));
        if (d == 0) return '0;
        return {RW'(n / d), RW'(n % d)};
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < L; i++) begin
                pq[i] <= '0;
                pr[i] <= '0;
            end
        end else if (clk_en) begin
            {pq[0], pr[0]} <= plant_div(div_numer, div_denom);
            for (int i = 1; i < L; i++) begin
                pq[i] <= pq[i-1];
                pr[i] <= pr[i-1];
            end
        end
    end

    assign div_quotient = pq[L-1];
    assign div_remain   = pr[L-1];

    // Reference model: pending operations with the enabled-edge index at which each must appear.
    typedef struct {
        int            id;
        logic [RW-1:0] q;
        logic [RW-1:0] r;
        bit            z;
        longint        due;
    } op_t;

    op_t           pend[$];
    op_t           got[$];
    int            dut_grants[$];
    int            m_last;
    longint        en_cnt;
    bit            e_valid;
    int            e_id;
    logic [RW-1:0] e_q;
    logic [RW-1:0] e_r;
    bit            e_z;
    int            checks;
    int            failures;

    task automatic check(input string tag, input logic [63:0] got_v, input logic [63:0] exp_v);
        checks++;
        if (got_v !== exp_v) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got_v, exp_v, $time);
        end
    endtask

    function automatic op_t expect_op(input int id, input logic [NW-1:0] num, input logic [DW-1:0] den);
        op_t    o;
        longint n;
        longint d;
        n    = longint'($signed(num));
        d    = longint'($signed(den));
        o.id = id;
        o.due = en_cnt + L + 1;
        if (d == 0) begin
            o.z = 1'b1;
            o.r = '0;
            o.q = (n >= 0) ? 32'h7FFF_FFFF : 32'h8000_0000;
        end else begin
            o.z = 1'b0;
            o.q = RW'(n / d);
            o.r = RW'(n % d);
        end
        return o;
    endfunction

    // One clock: check grant before the edge, advance the model on the edge, check results after it.
    task automatic cycle();
        logic [N-1:0] exp_ready;
        int           g;
        bit           en_edge;
        op_t          o;
        #1;
        exp_ready = '0;
        g = -1;
        if (clk_en && !reset) begin
            for (int k = 0; k < N; k++) begin
                if (g < 0 && req_valid[(m_last + 1 + k) % N] && chan_enable[(m_last + 1 + k) % N])
                    g = (m_last + 1 + k) % N;
            end
        end
        if (g >= 0) exp_ready[g] = 1'b1;
        check("req_ready", req_ready, exp_ready);
        for (int i = 0; i < N; i++) if (req_ready[i]) dut_grants.push_back(i);

        @(posedge clk);
        en_edge = clk_en && !reset;
        if (reset) begin
            pend.delete();
            m_last  = N - 1;
            e_valid = 1'b0;
        end else if (clk_en) begin
            en_cnt++;
            e_valid = 1'b0;
            if (pend.size() > 0 && pend[0].due == en_cnt) begin
                o       = pend.pop_front();
                e_valid = 1'b1;
                e_id    = o.id;
                e_q     = o.q;
                e_r     = o.r;
                e_z     = o.z;
            end
            if (g >= 0) begin
                m_last = g;
                pend.push_back(expect_op(g, req_numer[g*NW +: NW], req_denom[g*DW +: DW]));
            end
        end

        @(negedge clk);
        check("res_valid", res_valid, e_valid);
        check("in_flight", in_flight, pend.size());
        if (e_valid) begin
            check("res_id", res_id, e_id);
            check("res_quotient", res_quotient, e_q);
            check("res_remain", res_remain, e_r);
            check("res_div_zero", res_div_zero, e_z);
        end
        if (en_edge && res_valid) begin
            o.id = res_id;
            o.q  = res_quotient;
            o.r  = res_remain;
            o.z  = res_div_zero;
            o.due = en_cnt;
            got.push_back(o);
        end
    endtask

    task automatic idle(input int n);
        for (int c = 0; c < n; c++) cycle();
    endtask

    task automatic set_op(input int i, input longint n, input longint d);
        req_numer[i*NW +: NW] = NW'(n);
        req_denom[i*DW +: DW] = DW'(d);
    endtask

    task automatic reset_dut();
        reset     = 1'b1;
        req_valid = '0;
        cycle();
        reset = 1'b0;
        dut_grants.delete();
        got.delete();
    endtask

    function automatic longint rand_numer();
        logic [NW-1:0] raw;
        raw = NW'({$urandom(), $urandom()});
        if ($urandom_range(0, 3) == 0) return longint'($signed(raw));
        return longint'($urandom_range(0, 2_000_000)) - 1_000_000;
    endfunction

    function automatic longint rand_denom();
        logic [DW-1:0] raw;
        raw = DW'($urandom());
        case ($urandom_range(0, 5))
            0:       return 0;
            1:       return longint'($signed(raw));
            default: return longint'($urandom_range(0, 2000)) - 1000;
        endcase
    endfunction

    int lat;
    int en_edges;
    int mseq[3] = '{0, 1, 3};

    initial begin
        checks = 0;
        failures = 0;
        m_last = N - 1;
        en_cnt = 0;
        e_valid = 1'b0;
        e_id = 0;
        e_q = '0;
        e_r = '0;
        e_z = 1'b0;

        // Reset with clk_en low and every requester asking: reset must still act and gate grants.
        reset = 1'b1;
        clk_en = 1'b0;
        chan_enable = '1;
        req_valid = '1;
        req_numer = '0;
        req_denom = '0;
        idle(2);
        check("rst_div_numer", div_numer, 0);
        check("rst_div_denom", div_denom, 0);
        check("rst_res_id", res_id, 0);
        check("rst_res_quotient", res_quotient, 0);
        check("rst_res_remain", res_remain, 0);
        check("rst_res_div_zero", res_div_zero, 0);
        check("rst_in_flight", in_flight, 0);
        req_valid = '0;
        reset = 1'b0;
        clk_en = 1'b1;

        // Single operation: 1000 / 7 = 142 r 6, L+1 clocks after the handshake.
        set_op(0, 1000, 7);
        req_valid = 4'b0001;
        cycle();
        req_valid = '0;
        lat = -1;
        for (int c = 1; c <= 40; c++) begin
            cycle();
            if (res_valid && lat < 0) begin
                lat = c;
                check("single_q", res_quotient, 142);
                check("single_r", res_remain, 6);
                check("single_id", res_id, 0);
            end
        end
        check("single_latency", lat, L + 1);

        // Signed and zero-denominator results.
        reset_dut();
        req_valid = 4'b0010;
        set_op(1, -1000, 7);
        cycle();
        set_op(1, -5, 0);
        cycle();
        check("zero_denom_operand", div_denom, 1);
        set_op(1, 5, 0);
        cycle();
        req_valid = '0;
        idle(L + 4);
        check("signed_count", got.size(), 3);
        if (got.size() == 3) begin
            check("neg_q", got[0].q, 32'hFFFF_FF72);
            check("neg_r", got[0].r, 32'hFFFF_FFFA);
            check("neg_zero_q", got[1].q, 32'h8000_0000);
            check("neg_zero_r", got[1].r, 0);
            check("neg_zero_flag", got[1].z, 1);
            check("pos_zero_q", got[2].q, 32'h7FFF_FFFF);
            check("pos_zero_flag", got[2].z, 1);
        end

        // Fairness: all requesters valid, grants rotate and results return in the same order.
        reset_dut();
        for (int i = 0; i < N; i++) set_op(i, 100 * (i + 1), i + 1);
        req_valid = '1;
        idle(8);
        req_valid = '0;
        idle(L + 4);
        check("fair_grant_count", dut_grants.size(), 8);
        for (int i = 0; i < dut_grants.size() && i < 8; i++) check("fair_grant", dut_grants[i], i % N);
        check("fair_result_count", got.size(), 8);
        for (int i = 0; i < got.size() && i < 8; i++) check("fair_order", got[i].id, i % N);

        // clk_en gating: latency counted in enabled edges, outputs hold on disabled cycles.
        reset_dut();
        set_op(2, 12345, -17);
        req_valid = 4'b0100;
        cycle();
        req_valid = '1;
        lat = -1;
        en_edges = 0;
        for (int c = 0; c < 100 && lat < 0; c++) begin
            clk_en = (c % 2 == 1);
            cycle();
            req_valid = '0;
            if (clk_en) en_edges++;
            if (res_valid && lat < 0) lat = en_edges;
        end
        check("gate_latency", lat, L + 1);
        for (int c = 0; c < 6; c++) begin
            clk_en = (c % 2 == 1);
            cycle();
        end
        clk_en = 1'b1;
        idle(L + 4);

        // Masking: requester 2 disabled, the rest rotate 0,1,3.
        reset_dut();
        chan_enable = 4'b1011;
        req_valid = '1;
        idle(9);
        req_valid = '0;
        check("mask_grant_count", dut_grants.size(), 9);
        for (int i = 0; i < dut_grants.size() && i < 9; i++) check("mask_grant", dut_grants[i], mseq[i % 3]);
        idle(L + 4);
        chan_enable = '1;

        // Reset mid-flight drops all pending results and restores priority to requester 0.
        reset_dut();
        req_valid = '1;
        idle(3);
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        req_valid = '0;
        check("midrst_in_flight", in_flight, 0);
        got.delete();
        idle(L + 6);
        check("midrst_no_result", got.size(), 0);
        dut_grants.delete();
        req_valid = '1;
        cycle();
        req_valid = '0;
        check("midrst_next_grant", (dut_grants.size() > 0) ? dut_grants[0] : -1, 0);
        idle(L + 4);

        // Randomised traffic against the reference model.
        reset_dut();
        for (int c = 0; c < 3000; c++) begin
            clk_en      = ($urandom_range(0, 9) != 0);
            req_valid   = N'($urandom());
            chan_enable = ($urandom_range(0, 3) == 0) ? N'($urandom()) : '1;
            reset       = ($urandom_range(0, 499) == 0);
            for (int i = 0; i < N; i++) set_op(i, rand_numer(), rand_denom());
            cycle();
        end
        reset = 1'b0;
        req_valid = '0;
        clk_en = 1'b1;
        idle(L + 4);
        check("final_in_flight", in_flight, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
